// File: rtl/prio_encoder_rr_if.sv
`default_nettype none
// ============================================================================
// Module   : prio_encoder_rr_if
// Purpose  : Request / grant bundle between request sources, the priority
//            encoder and the consumer of the encoded index.
// Revision : 1.0  initial release
// ============================================================================
interface prio_encoder_rr_if #(
   parameter int N = 4
) ();
   localparam int W = (N > 1) ? $clog2(N) : 1;

   logic [N-1:0] req;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_idx;
   logic [N-1:0] out_onehot;
   logic         any_req;

   modport master (
      input  req,
      input  out_ready,
      output out_valid,
      output out_idx,
      output out_onehot,
      output any_req
   );

   modport slave (
      output req,
      output out_ready,
      input  out_valid,
      input  out_idx,
      input  out_onehot,
      input  any_req
   );
endinterface
`default_nettype wire

// File: rtl/prio_encoder_rr.sv
`default_nettype none
// ============================================================================
// Module   : prio_encoder_rr
// Purpose  : Registered N-input priority encoder, fixed or round-robin order,
//            with a valid/ready output that holds each grant until accepted.
// Revision : 1.0  initial release
// ============================================================================
module prio_encoder_rr #(
   parameter int N       = 4,
   parameter int RR_MODE = 0
) (
   input  logic               clk,
   input  logic               rst,
   prio_encoder_rr_if.master  bus
);
   localparam int W = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_HOLD = 1'b1
   } state_t;

   state_t       r_state;
   state_t       w_state_nxt;
   logic [W-1:0] r_idx;
   logic [W-1:0] w_idx_nxt;
   logic [N-1:0] r_onehot;
   logic [N-1:0] w_onehot_nxt;
   logic [W-1:0] r_ptr;
   logic [W-1:0] w_ptr_nxt;
   logic         r_any;

   logic         w_any_now;
   logic         w_accept;
   logic [W-1:0] w_base;
   logic [W-1:0] w_win;
   logic [N-1:0] w_win_oh;

   assign w_any_now = |bus.req;
   assign w_accept  = (r_state == S_HOLD) && bus.out_ready;

   // At accept the search starts below the index being accepted, so the
   // re-arbitration in that cycle already sees the updated pointer.
   generate
      if (N == 1) begin : g_single
         assign w_base   = '0;
         assign w_win    = '0;
         assign w_win_oh = 1'b1;
      end else begin : g_multi
         assign w_base = (RR_MODE != 0) ? (w_accept ? r_idx : r_ptr) : '0;

         // Walk from the lowest priority to the highest so the last hit wins.
         always_comb begin
            int c;
            w_win = '0;
            for (int s = N; s >= 1; s--) begin
               c = (int'(w_base) + N - s) % N;
               if (bus.req[c[W-1:0]]) begin
                  w_win = c[W-1:0];
               end
            end
         end

         always_comb begin
            w_win_oh        = '0;
            w_win_oh[w_win] = 1'b1;
         end
      end
   endgenerate

   always_comb begin
      w_state_nxt  = r_state;
      w_idx_nxt    = r_idx;
      w_onehot_nxt = r_onehot;
      w_ptr_nxt    = r_ptr;
      case (r_state)
         S_IDLE: begin
            if (w_any_now) begin
               w_state_nxt  = S_HOLD;
               w_idx_nxt    = w_win;
               w_onehot_nxt = w_win_oh;
            end
         end
         S_HOLD: begin
            if (w_accept) begin
               if ((RR_MODE != 0) && (N > 1)) begin
                  w_ptr_nxt = r_idx;
               end
               if (w_any_now) begin
                  w_idx_nxt    = w_win;
                  w_onehot_nxt = w_win_oh;
               end else begin
                  w_state_nxt  = S_IDLE;
                  w_onehot_nxt = '0;
               end
            end
         end
         default: begin
            w_state_nxt  = S_IDLE;
            w_onehot_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_idx    <= '0;
         r_onehot <= '0;
         r_ptr    <= '0;
         r_any    <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_idx    <= w_idx_nxt;
         r_onehot <= w_onehot_nxt;
         r_ptr    <= w_ptr_nxt;
         r_any    <= w_any_now;
      end
   end

   assign bus.out_valid  = (r_state == S_HOLD);
   assign bus.out_idx    = r_idx;
   assign bus.out_onehot = r_onehot;
   assign bus.any_req    = r_any;
endmodule
`default_nettype wire

// File: tb/tb_prio_encoder_rr.sv
`default_nettype none
// ============================================================================
// Module   : tb_prio_encoder_rr
// Purpose  : Fixed and round-robin encoders side by side, checked against a
//            queue-based model of the grant rules.
// Revision : 1.0  initial release
// ============================================================================
module tb_prio_encoder_rr;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] req = 4'b0000;
   logic       rdy = 1'b0;

   always #5 clk = ~clk;

   prio_encoder_rr_if #(.N(4)) if_fx ();
   prio_encoder_rr_if #(.N(4)) if_rr ();

   assign if_fx.req       = req;
   assign if_fx.out_ready = rdy;
   assign if_rr.req       = req;
   assign if_rr.out_ready = rdy;

   prio_encoder_rr #(.N(4), .RR_MODE(0)) dut_fx (.clk(clk), .rst(rst), .bus(if_fx.master));
   prio_encoder_rr #(.N(4), .RR_MODE(1)) dut_rr (.clk(clk), .rst(rst), .bus(if_rr.master));

   typedef struct {
      bit v0;
      bit v1;
      bit any;
   } rec_t;

   int   n_tests = 0;
   int   n_fail  = 0;
   bit   mon_en  = 1'b0;
   rec_t rq[$];
   int   gq0[$];
   int   gq1[$];
   int   log_fx[$];
   int   log_rr[$];

   // Model: per mode, whether a grant is pending, its index, and the last accepted index.
   int   m_v[2];
   int   m_i[2];
   int   m_p[2];
   bit   m_any;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Search order is base-1, base-2, ... wrapping modulo 4.
   function automatic int pick(input logic [3:0] r, input int base);
      for (int off = 1; off <= 4; off++) begin
         int c;
         c = (base - off + 4) % 4;
         if (r[c]) return c;
      end
      return 0;
   endfunction

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         m_v[m] = 0;
         m_i[m] = 0;
         m_p[m] = 0;
      end
      m_any = 1'b0;
   endtask

   // Applies inputs for the coming edge and predicts what that edge produces.
   task automatic cycle(input logic [3:0] r, input logic rd);
      rec_t rc;
      @(posedge clk);
      #1;
      rc.v0  = (m_v[0] != 0);
      rc.v1  = (m_v[1] != 0);
      rc.any = m_any;
      rq.push_back(rc);
      req   = r;
      rdy   = rd;
      m_any = (r != 4'b0000);
      for (int m = 0; m < 2; m++) begin
         if (m_v[m] != 0 && rd && m == 1) m_p[m] = m_i[m];
         if (m_v[m] == 0 || rd) begin
            if (r != 4'b0000) begin
               m_i[m] = pick(r, (m == 1) ? m_p[m] : 0);
               m_v[m] = 1;
               if (m == 0) gq0.push_back(m_i[m]);
               else        gq1.push_back(m_i[m]);
            end else begin
               m_v[m] = 0;
            end
         end
      end
   endtask

   task automatic monitor();
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (rq.size() > 0) begin
               rec_t r;
               r = rq.pop_front();
               chk("valid_fx", 32'(if_fx.out_valid), 32'(r.v0));
               chk("valid_rr", 32'(if_rr.out_valid), 32'(r.v1));
               chk("any_fx", 32'(if_fx.any_req), 32'(r.any));
               chk("any_rr", 32'(if_rr.any_req), 32'(r.any));
            end
            chk("onehot_fx", 32'(if_fx.out_onehot),
                if_fx.out_valid ? (32'd1 << if_fx.out_idx) : 32'd0);
            chk("onehot_rr", 32'(if_rr.out_onehot),
                if_rr.out_valid ? (32'd1 << if_rr.out_idx) : 32'd0);
            if (if_fx.out_valid && rdy) begin
               if (gq0.size() == 0) chk("grant_fx_unexpected", 32'(if_fx.out_idx), 32'hFFFF_FFFF);
               else                 chk("grant_fx", 32'(if_fx.out_idx), 32'(gq0.pop_front()));
               log_fx.push_back(int'(if_fx.out_idx));
            end
            if (if_rr.out_valid && rdy) begin
               if (gq1.size() == 0) chk("grant_rr_unexpected", 32'(if_rr.out_idx), 32'hFFFF_FFFF);
               else                 chk("grant_rr", 32'(if_rr.out_idx), 32'(gq1.pop_front()));
               log_rr.push_back(int'(if_rr.out_idx));
            end
         end
      end
   endtask

   task automatic chk_log(input string nm, input int q[$], input int exp[], input int n);
      if (q.size() < n) begin
         chk({nm, "_count"}, 32'(q.size()), 32'(n));
      end else begin
         for (int i = 0; i < n; i++) chk(nm, 32'(q[i]), 32'(exp[i]));
      end
   endtask

   initial begin
      int exp_wrap[]  = '{0, 2, 0};
      int exp_rr[]    = '{3, 2, 1, 0, 3};
      int exp_fx[]    = '{3, 3, 3};
      model_reset();
      fork
         monitor();
      join_none

      // Reset and idle
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", 32'(if_rr.out_valid), 32'd0);
      chk("rst_onehot", 32'(if_rr.out_onehot), 32'd0);
      chk("rst_idx", 32'(if_fx.out_idx), 32'd0);
      chk("rst_any", 32'(if_fx.any_req), 32'd0);
      @(posedge clk);
      #1;
      rst    = 1'b0;
      mon_en = 1'b1;
      repeat (5) cycle(4'b0000, 1'b1);

      // Sweep every request pattern with the consumer always ready
      for (int r = 0; r < 16; r++) cycle(4'(r), 1'b1);

      // Backpressure: the latched grant survives a change of req
      cycle(4'b0000, 1'b1);
      cycle(4'b0010, 1'b0);
      repeat (4) cycle(4'b1000, 1'b0);
      cycle(4'b1000, 1'b1);
      cycle(4'b0000, 1'b1);

      // Random traffic
      for (int i = 0; i < 400; i++) cycle(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));

      // Round-robin wrap with sparse requests
      repeat (2) cycle(4'b0000, 1'b1);
      log_fx.delete();
      log_rr.delete();
      cycle(4'b0001, 1'b1);
      cycle(4'b0101, 1'b1);
      cycle(4'b0101, 1'b1);
      cycle(4'b0000, 1'b1);
      @(negedge clk);
      chk_log("wrap_rr", log_rr, exp_wrap, 3);

      // Leave the pointer at 2 with a grant of 2 pending, then reset mid-hold
      cycle(4'b0100, 1'b1);
      cycle(4'b0100, 1'b1);
      cycle(4'b0100, 1'b0);
      @(negedge clk);
      chk("pre_reset_valid", 32'(if_rr.out_valid), 32'd1);
      chk("pre_reset_idx", 32'(if_rr.out_idx), 32'd2);
      mon_en = 1'b0;
      #2;
      rst = 1'b1;
      req = 4'b0000;
      rdy = 1'b0;
      #1;
      chk("async_valid_rr", 32'(if_rr.out_valid), 32'd0);
      chk("async_onehot_rr", 32'(if_rr.out_onehot), 32'd0);
      chk("async_valid_fx", 32'(if_fx.out_valid), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      rq.delete();
      gq0.delete();
      gq1.delete();
      log_fx.delete();
      log_rr.delete();
      model_reset();
      mon_en = 1'b1;

      // Fairness under full load after reset
      repeat (6) cycle(4'b1111, 1'b1);
      cycle(4'b0000, 1'b1);
      @(negedge clk);
      chk_log("fair_rr", log_rr, exp_rr, 5);
      chk_log("fair_fx", log_fx, exp_fx, 3);

      repeat (3) cycle(4'b0000, 1'b1);
      @(negedge clk);
      chk("grants_left_fx", 32'(gq0.size()), 32'd0);
      chk("grants_left_rr", 32'(gq1.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
